sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Parametrised multi-channel front end for the `sdram` controller. It accepts burst read/write requests from `NUM_CH` independent clients, selects one at a time by round-robin, and drives the controller's single row/col/ba + burst-data interface. It routes completions and read bursts back to the owning channel, and aborts with an error on a watchdog timeout. It sits between system masters (frame writers, readers) and `sdram`, replacing direct single-master hookup.

## Interface
- `NUM_CH`, 2, number of client channels (1..8)
- `DATA_W`, 16, SDRAM data word width
- `BURST`, 4, words per burst (matches controller burst length)
- `BA_W`, 3, bank address width
- `ROW_W`, 14, row address width
- `COL_W`, 9, column address width
- `TIMEOUT`, 1023, max cycles in WAIT before abort (ADDR_W = BA_W+ROW_W+COL_W)

Ports:
- `clock`  in  1  system clock, all logic on rising edge
- `srst`  in  1  synchronous, active-high reset
- `ch_req`  in  NUM_CH  per-channel request level
- `ch_we`  in  NUM_CH  1 = write burst, 0 = read burst
- `ch_addr`  in  NUM_CH x ADDR_W  {ba,row,col} start address
- `ch_wdata`  in  NUM_CH x BURST x DATA_W  write burst payload
- `ch_ack`  out  NUM_CH  one-cycle completion pulse, owning channel only
- `ch_err`  out  1  valid with `ch_ack`; 1 = aborted by timeout
- `ch_rvalid`  out  NUM_CH  one-cycle read-data valid, owning channel only
- `ch_rdata`  out  BURST x DATA_W  read burst, shared bus, valid with `ch_rvalid`
- `ctl_ba`/`ctl_row`/`ctl_col`  out  BA_W/ROW_W/COL_W  address to controller
- `ctl_wdata`  out  BURST x DATA_W  write burst to controller
- `ctl_wtrig`  out  1  one-cycle write start
- `ctl_rtrig`  out  1  one-cycle read start
- `ctl_wdone`  in  1  controller write-complete pulse
- `ctl_rdone`  in  1  controller read-complete pulse
- `ctl_rdata`  in  BURST x DATA_W  read burst, valid with `ctl_rdone`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `ch_req` bit is set, pick the winner `g`. The search starts at `last+1` and wraps modulo NUM_CH. Latch `g`, `ch_we[g]`, `ch_addr[g]` and `ch_wdata[g]`, then go to ISSUE. If no bit is set, stay in IDLE.
- ISSUE: exactly one cycle. Assert `ctl_wtrig` (write) or `ctl_rtrig` (read). Clear the watchdog counter. Go to WAIT.
- WAIT: sample the done pulse matching the latched direction; the other done pulse is ignored. On done, latch `ctl_rdata` if reading and go to RESP. If the counter reaches TIMEOUT, set the error flag and go to RESP.
- RESP: one cycle. Pulse `ch_ack[g]`; drive `ch_err` = error flag. For a read without error, also pulse `ch_rvalid[g]`. Set `last = g` and return to IDLE.
- Latched address and data are held stable on the `ctl_*` outputs from ISSUE through WAIT. Client inputs may change freely after the IDLE-to-ISSUE edge.
- If a client drops `ch_req` after it is latched, the transaction still completes and is acked. If a client drops `ch_req` before it is latched, it is not served.
- Clients must drop `ch_req` on the cycle they see `ch_ack`. Otherwise a new transaction is started.
- `ch_rdata` holds its last value and is meaningful only with `ch_rvalid`.

## Timing
- Reset: state IDLE, `last` = NUM_CH-1 (channel 0 wins first). All `ch_ack`, `ch_rvalid`, `ch_err`, `ctl_wtrig` and `ctl_rtrig` are 0. `ctl_*` address/data and `ch_rdata` are 0. Watchdog counter is 0.
- A reset in any state, including mid-WAIT, returns to IDLE next cycle with no ack. A late controller done pulse after reset is ignored in IDLE.
- Request latency: `ch_req` high at cycle n in IDLE gives trig at n+1. A done pulse at cycle m in WAIT gives ack/rvalid at m+1, then IDLE at m+2. The minimum transaction is 4 cycles, so the next grant is sampled at m+2.
- Watchdog: the counter increments every WAIT cycle and is ceil(log2(TIMEOUT+1)) bits wide. The abort ack comes TIMEOUT+2 cycles after trig.
- If done and timeout occur in the same cycle, done wins: `ch_err` = 0.
- Fairness: with all channels requesting continuously, grants rotate 0,1,…,NUM_CH-1,0, so no channel waits more than NUM_CH-1 transactions.

## Structure
- Package `sdram_pkg` holds the default widths (BA_W, ROW_W, COL_W, DATA_W, BURST), the `sdram_addr_t` packed struct {ba,row,col}, and the `arb_state_e` enum. The existing `sdram` controller imports the same package.
- Sub-module `rr_arbiter`: combinational round-robin priority pick. Inputs are `req[NUM_CH]` and `last`; outputs are `grant_idx` and `any`. It is instantiated once and verified standalone.

## Test plan
- Channels 0 and 1 both request a write at once after reset → ch0 trig first; ch0 ack; then ch1 trig; `ctl_wdata` = ch1's {4,5,6,7}.
- Write at addr 0x000004 with data {4,5,6,7}, then a read at addr 4 from ch1 with the model returning {4,5,6,7} → `ch_rvalid[1]` pulses once, `ch_rdata` = {4,5,6,7}, and `ch_rvalid[0]` stays 0.
- All NUM_CH=4 channels requesting continuously for 12 transactions → grant order 0,1,2,3 repeated 3 times.
- Controller never returns done, TIMEOUT=15 → `ch_ack[g]` with `ch_err`=1 exactly 17 cycles after trig; FSM back in IDLE.
- `srst` asserted 3 cycles into WAIT → next cycle all outputs 0 and state IDLE. A following `ctl_wdone` produces no ack.
- `ctl_rdone` pulsed during a write WAIT → ignored. The following `ctl_wdone` acks with `ch_err`=0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared widths, address struct and arbiter state encoding for the sdram
// controller and its multi-channel front end.
package sdram_pkg;

   localparam int BA_W   = 3;
   localparam int ROW_W  = 14;
   localparam int COL_W  = 9;
   localparam int DATA_W = 16;
   localparam int BURST  = 4;

   typedef struct packed {
      logic [BA_W-1:0]  ba;
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } sdram_addr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } arb_state_e;

endpackage

// File: rtl/sdram_port_arbiter_rr.sv
// Combinational round-robin pick: the search starts one past the last served
// channel and wraps, so the most recent winner has the lowest priority.
module rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  last,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              any
);
   import sdram_pkg::*;

   assign any = |req;

   // Walk from the farthest offset down so the nearest requester is written last.
   always_comb begin
      int idx;
      idx       = 0;
      grant_idx = '0;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = (int'(last) + i) % NUM_CH;
         if (req[idx]) grant_idx = IDX_W'(idx);
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-channel burst front end for the sdram controller: round-robin grant,
// one transaction in flight, completion routed back to the owner, watchdog abort.
module sdram_port_arbiter #(
   parameter int NUM_CH  = 2,
   parameter int DATA_W  = sdram_pkg::DATA_W,
   parameter int BURST   = sdram_pkg::BURST,
   parameter int BA_W    = sdram_pkg::BA_W,
   parameter int ROW_W   = sdram_pkg::ROW_W,
   parameter int COL_W   = sdram_pkg::COL_W,
   parameter int TIMEOUT = 1023
) (
   input  logic                                   clock,
   input  logic                                   srst,
   input  logic [NUM_CH-1:0]                      ch_req,
   input  logic [NUM_CH-1:0]                      ch_we,
   input  logic [NUM_CH*(BA_W+ROW_W+COL_W)-1:0]   ch_addr,
   input  logic [NUM_CH*BURST*DATA_W-1:0]         ch_wdata,
   output logic [NUM_CH-1:0]                      ch_ack,
   output logic                                   ch_err,
   output logic [NUM_CH-1:0]                      ch_rvalid,
   output logic [BURST*DATA_W-1:0]                ch_rdata,
   output logic [BA_W-1:0]                        ctl_ba,
   output logic [ROW_W-1:0]                       ctl_row,
   output logic [COL_W-1:0]                       ctl_col,
   output logic [BURST*DATA_W-1:0]                ctl_wdata,
   output logic                                   ctl_wtrig,
   output logic                                   ctl_rtrig,
   input  logic                                   ctl_wdone,
   input  logic                                   ctl_rdone,
   input  logic [BURST*DATA_W-1:0]                ctl_rdata
);
   import sdram_pkg::*;

   localparam int ADDR_W = BA_W + ROW_W + COL_W;
   localparam int BW     = BURST * DATA_W;
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_e        state;
   logic [IDX_W-1:0]  g, last, grant_idx;
   logic              any_req;
   logic              we_l;
   logic [CNT_W-1:0]  wdog;
   logic              done;

   rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
      .req       (ch_req),
      .last      (last),
      .grant_idx (grant_idx),
      .any       (any_req)
   );

   // Only the done pulse matching the latched direction counts.
   assign done = we_l ? ctl_wdone : ctl_rdone;

   always_ff @(posedge clock) begin
      if (srst) begin
         state     <= ST_IDLE;
         g         <= '0;
         last      <= IDX_W'(NUM_CH - 1);
         we_l      <= 1'b0;
         wdog      <= '0;
         ch_ack    <= '0;
         ch_err    <= 1'b0;
         ch_rvalid <= '0;
         ch_rdata  <= '0;
         ctl_ba    <= '0;
         ctl_row   <= '0;
         ctl_col   <= '0;
         ctl_wdata <= '0;
         ctl_wtrig <= 1'b0;
         ctl_rtrig <= 1'b0;
      end else begin
         ctl_wtrig <= 1'b0;
         ctl_rtrig <= 1'b0;
         ch_ack    <= '0;
         ch_rvalid <= '0;
         ch_err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Trig is registered here so it is visible during the ISSUE cycle.
               if (any_req) begin
                  g                         <= grant_idx;
                  we_l                      <= ch_we[grant_idx];
                  {ctl_ba, ctl_row, ctl_col} <= ch_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                  ctl_wdata                 <= ch_wdata[int'(grant_idx)*BW +: BW];
                  ctl_wtrig                 <= ch_we[grant_idx];
                  ctl_rtrig                 <= ~ch_we[grant_idx];
                  state                     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wdog  <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (done) begin
                  ch_ack <= NUM_CH'(1) << g;
                  if (!we_l) begin
                     ch_rvalid <= NUM_CH'(1) << g;
                     ch_rdata  <= ctl_rdata;
                  end
                  state <= ST_RESP;
               end else if (wdog == CNT_W'(TIMEOUT)) begin
                  ch_ack <= NUM_CH'(1) << g;
                  ch_err <= 1'b1;
                  state  <= ST_RESP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            ST_RESP: begin
               last  <= g;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: four channels, short watchdog, the
// controller side driven by hand.
module tb_sdram_port_arbiter;

   localparam int NUM_CH  = 4;
   localparam int DATA_W  = 16;
   localparam int BURST   = 4;
   localparam int BA_W    = 3;
   localparam int ROW_W   = 14;
   localparam int COL_W   = 9;
   localparam int TIMEOUT = 15;
   localparam int ADDR_W  = BA_W + ROW_W + COL_W;
   localparam int BW      = BURST * DATA_W;

   logic                       clock = 1'b0;
   logic                       srst;
   logic [NUM_CH-1:0]          ch_req, ch_we;
   logic [NUM_CH*ADDR_W-1:0]   ch_addr;
   logic [NUM_CH*BW-1:0]       ch_wdata;
   logic [NUM_CH-1:0]          ch_ack, ch_rvalid;
   logic                       ch_err;
   logic [BW-1:0]              ch_rdata;
   logic [BA_W-1:0]            ctl_ba;
   logic [ROW_W-1:0]           ctl_row;
   logic [COL_W-1:0]           ctl_col;
   logic [BW-1:0]              ctl_wdata;
   logic                       ctl_wtrig, ctl_rtrig;
   logic                       ctl_wdone, ctl_rdone;
   logic [BW-1:0]              ctl_rdata;

   int checks = 0;
   int errors = 0;

   sdram_port_arbiter #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .BURST(BURST), .BA_W(BA_W),
      .ROW_W(ROW_W), .COL_W(COL_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock), .srst(srst), .ch_req(ch_req), .ch_we(ch_we),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_err(ch_err),
      .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata), .ctl_ba(ctl_ba),
      .ctl_row(ctl_row), .ctl_col(ctl_col), .ctl_wdata(ctl_wdata),
      .ctl_wtrig(ctl_wtrig), .ctl_rtrig(ctl_rtrig), .ctl_wdone(ctl_wdone),
      .ctl_rdone(ctl_rdone), .ctl_rdata(ctl_rdata)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ch(input int c, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [BW-1:0] d);
      ch_we[c]               = we;
      ch_addr[c*ADDR_W +: ADDR_W] = a;
      ch_wdata[c*BW +: BW]   = d;
   endtask

   // Advance until a trig is visible; an expired bound counts as a failed check.
   task automatic wait_trig(input string tag);
      int n;
      n = 0;
      while (!(ctl_wtrig || ctl_rtrig) && n < 20) begin
         cyc();
         n++;
      end
      if (!(ctl_wtrig || ctl_rtrig)) chk({tag, "_trig_timeout"}, 64'(n), 64'(0));
   endtask

   function automatic logic [BW-1:0] burst4(input int base);
      logic [BW-1:0] b;
      for (int i = 0; i < BURST; i++) b[i*DATA_W +: DATA_W] = DATA_W'(base + i);
      return b;
   endfunction

   initial begin
      logic [BW-1:0] d0123, d4567, d1234;
      int n;
      d0123 = burst4(0);
      d4567 = burst4(4);
      d1234 = burst4(1);
      srst = 1'b1; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
      ctl_wdone = 1'b0; ctl_rdone = 1'b0; ctl_rdata = '0;
      cyc(); cyc();
      srst = 1'b0;
      cyc();

      // Reset state
      chk("rst_ack",   64'(ch_ack), 64'(0));
      chk("rst_rv",    64'(ch_rvalid), 64'(0));
      chk("rst_err",   64'(ch_err), 64'(0));
      chk("rst_trig",  64'({ctl_wtrig, ctl_rtrig}), 64'(0));
      chk("rst_addr",  64'({ctl_ba, ctl_row, ctl_col}), 64'(0));
      chk("rst_wdata", 64'(ctl_wdata), 64'(0));
      chk("rst_rdata", 64'(ch_rdata), 64'(0));

      // Two simultaneous writes: channel 0 first, then channel 1
      set_ch(0, 1'b1, 26'h10, d1234);
      set_ch(1, 1'b1, 26'h000004, d4567);
      ch_req = 4'b0011;
      cyc();
      chk("w0_trig",  64'(ctl_wtrig), 64'(1));
      chk("w0_rtrig", 64'(ctl_rtrig), 64'(0));
      chk("w0_col",   64'(ctl_col), 64'(16));
      chk("w0_wdata", 64'(ctl_wdata), 64'(d1234));
      cyc();
      ctl_wdone = 1'b1;
      cyc();
      ctl_wdone = 1'b0;
      chk("w0_ack", 64'(ch_ack), 64'(4'b0001));
      chk("w0_err", 64'(ch_err), 64'(0));
      ch_req = 4'b0010;
      cyc();
      chk("w0_ack_once", 64'(ch_ack), 64'(0));
      cyc();
      chk("w1_trig",  64'(ctl_wtrig), 64'(1));
      chk("w1_addr",  64'({ctl_ba, ctl_row, ctl_col}), 64'(4));
      chk("w1_wdata", 64'(ctl_wdata), 64'(d4567));
      cyc();
      ctl_wdone = 1'b1;
      cyc();
      ctl_wdone = 1'b0;
      chk("w1_ack", 64'(ch_ack), 64'(4'b0010));
      ch_req = '0;
      cyc();

      // Read back from channel 1; request dropped right after it is latched
      set_ch(1, 1'b0, 26'h000004, '0);
      ch_req = 4'b0010;
      cyc();
      chk("r1_rtrig", 64'(ctl_rtrig), 64'(1));
      chk("r1_wtrig", 64'(ctl_wtrig), 64'(0));
      ch_req = '0;
      cyc();
      ctl_rdone = 1'b1;
      ctl_rdata = d4567;
      cyc();
      ctl_rdone = 1'b0;
      ctl_rdata = d0123;
      chk("r1_rvalid", 64'(ch_rvalid), 64'(4'b0010));
      chk("r1_ack",    64'(ch_ack), 64'(4'b0010));
      chk("r1_rdata",  64'(ch_rdata), 64'(d4567));
      cyc();
      chk("r1_rv_once",   64'(ch_rvalid), 64'(0));
      chk("r1_rdata_hold", 64'(ch_rdata), 64'(d4567));
      cyc();
      chk("r1_no_reissue", 64'({ctl_wtrig, ctl_rtrig}), 64'(0));

      // Fairness: reset so channel 0 wins, then all four request continuously
      srst = 1'b1; cyc(); srst = 1'b0;
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, ADDR_W'(c), burst4(c * 8));
      ch_req = 4'b1111;
      for (int i = 0; i < 12; i++) begin
         wait_trig("rr");
         chk($sformatf("rr_grant%0d", i), 64'(ctl_col), 64'(i % NUM_CH));
         cyc();
         ctl_wdone = 1'b1;
         cyc();
         ctl_wdone = 1'b0;
         chk($sformatf("rr_ack%0d", i), 64'(ch_ack), 64'(4'b0001 << (i % NUM_CH)));
      end
      ch_req = '0;
      cyc(); cyc();

      // Watchdog abort on channel 2; ack with error TIMEOUT+2 cycles after trig
      set_ch(2, 1'b1, 26'h22, d0123);
      ch_req = 4'b0100;
      wait_trig("to");
      n = 0;
      while (ch_ack == '0 && n < 40) begin
         cyc();
         n++;
      end
      chk("to_latency", 64'(n), 64'(TIMEOUT + 2));
      chk("to_ack",     64'(ch_ack), 64'(4'b0100));
      chk("to_err",     64'(ch_err), 64'(1));
      set_ch(3, 1'b1, 26'h3, d4567);
      ch_req = 4'b1000;
      cyc();
      chk("to_idle_notrig", 64'({ctl_wtrig, ctl_rtrig}), 64'(0));
      chk("to_err_clr",     64'(ch_err), 64'(0));
      cyc();
      chk("to_idle_trig", 64'(ctl_wtrig), 64'(1));
      chk("to_next_col",  64'(ctl_col), 64'(3));
      ch_req = '0;
      cyc();
      ctl_wdone = 1'b1;
      cyc();
      ctl_wdone = 1'b0;
      chk("to_next_ack", 64'(ch_ack), 64'(4'b1000));
      cyc();

      // Done in the same cycle the watchdog expires: done wins
      ch_req = 4'b0100;
      wait_trig("tie");
      ch_req = '0;
      for (int i = 0; i < TIMEOUT + 1; i++) cyc();
      ctl_wdone = 1'b1;
      cyc();
      ctl_wdone = 1'b0;
      chk("tie_ack", 64'(ch_ack), 64'(4'b0100));
      chk("tie_err", 64'(ch_err), 64'(0));
      cyc();

      // Reset three cycles into WAIT, then a late done pulse
      set_ch(0, 1'b1, 26'h5, d4567);
      ch_req = 4'b0001;
      wait_trig("srst");
      cyc(); cyc(); cyc();
      srst = 1'b1;
      ch_req = '0;
      cyc();
      srst = 1'b0;
      chk("srst_ack",   64'(ch_ack), 64'(0));
      chk("srst_trig",  64'({ctl_wtrig, ctl_rtrig}), 64'(0));
      chk("srst_addr",  64'({ctl_ba, ctl_row, ctl_col}), 64'(0));
      chk("srst_wdata", 64'(ctl_wdata), 64'(0));
      ctl_wdone = 1'b1;
      cyc();
      ctl_wdone = 1'b0;
      chk("srst_late_done", 64'(ch_ack), 64'(0));
      cyc();
      chk("srst_late_done2", 64'(ch_ack), 64'(0));

      // Wrong-direction done during a write WAIT is ignored
      set_ch(1, 1'b1, 26'h7, d0123);
      ch_req = 4'b0010;
      wait_trig("ign");
      ch_req = '0;
      cyc();
      ctl_rdone = 1'b1;
      cyc();
      ctl_rdone = 1'b0;
      chk("ign_rdone_ack", 64'(ch_ack), 64'(0));
      cyc();
      chk("ign_rdone_ack2", 64'(ch_ack), 64'(0));
      ctl_wdone = 1'b1;
      cyc();
      ctl_wdone = 1'b0;
      chk("ign_wdone_ack", 64'(ch_ack), 64'(4'b0010));
      chk("ign_wdone_err", 64'(ch_err), 64'(0));
      chk("ign_rvalid",    64'(ch_rvalid), 64'(0));
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
